spec_ctrl: RTL

SPEC_CTRL -- requirements
Module: spec_ctrl

---
 rtl/spec_ctrl_if.sv | 27 ++
 rtl/spec_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/spec_ctrl_if.sv
// Bus between the branch front end and the speculation-tag controller.
// alloc_req is a level request: it is taken on any edge where the pool is not full and no miss wins that edge.
// The grant appears as a one-cycle newSpecValid pulse in the following cycle. resolve_valid is a single-cycle strobe.
interface spec_ctrl_if #(
    parameter int TAGW = 4
);
    logic            alloc_req;
    logic            resolve_valid;
    logic [TAGW-1:0] resolve_id;
    logic            resolve_miss;
    logic            newSpecValid;
    logic [TAGW-1:0] newSpecId;
    logic            invalid;
    logic [TAGW:0]   missId;
    logic            full;
    logic [TAGW:0]   count;

    modport master (
        output alloc_req, resolve_valid, resolve_id, resolve_miss,
        input  newSpecValid, newSpecId, invalid, missId, full, count
    );

    modport slave (
        input  alloc_req, resolve_valid, resolve_id, resolve_miss,
        output newSpecValid, newSpecId, invalid, missId, full, count
    );
endinterface

// File: rtl/spec_ctrl.sv
// Speculation-tag ring: allocates branch tags in order, retires resolved tags from the head,
// and squashes everything younger than a mispredicted branch.
module spec_ctrl #(
    parameter int TAGW = 4
) (
    input  logic        clk,
    input  logic        rst,
    spec_ctrl_if.slave  bus
);
    localparam int N  = 1 << TAGW;
    localparam int PW = TAGW + 1;

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [N-1:0]    valid_q, valid_d, resolved_q, resolved_d;
    logic            new_spec_valid_q, new_spec_valid_d;
    logic [TAGW-1:0] new_spec_id_q, new_spec_id_d;
    logic            invalid_q, invalid_d;
    logic [PW-1:0]   miss_id_q, miss_id_d;
    logic            full_q, full_d;
    logic [PW-1:0]   count_q, count_d;

    logic [TAGW-1:0] head_idx, tail_idx, miss_off, ent_off;
    logic [PW-1:0]   count_cur, miss_pos;
    logic            hit, do_miss, do_resolve, do_retire, do_alloc;

    always_comb begin
        head_idx   = head_q[TAGW-1:0];
        tail_idx   = tail_q[TAGW-1:0];
        count_cur  = tail_q - head_q;
        hit        = bus.resolve_valid && valid_q[bus.resolve_id];
        do_miss    = hit && bus.resolve_miss;
        do_resolve = hit && !bus.resolve_miss;
        do_retire  = (head_q != tail_q) && resolved_q[head_idx];
        do_alloc   = bus.alloc_req && (count_cur != PW'(N)) && !do_miss;
        // Ring offset from head gives the phase-correct position of the missed tag.
        miss_off   = bus.resolve_id - head_idx;
        miss_pos   = head_q + {1'b0, miss_off};
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        ent_off    = '0;
        if (do_resolve) resolved_d[bus.resolve_id] = 1'b1;
        if (do_retire) begin
            valid_d[head_idx] = 1'b0;
            // A miss on the head itself collapses the ring onto head; head must not pass tail.
            if (!(do_miss && miss_off == '0)) head_d = head_q + 1'b1;
        end
        if (do_miss) begin
            tail_d = miss_pos;
            for (int i = 0; i < N; i++) begin
                ent_off = TAGW'(i) - head_idx;
                if (ent_off >= miss_off) valid_d[i] = 1'b0;
            end
        end
        if (do_alloc) begin
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            tail_d               = tail_q + 1'b1;
        end
    end

    always_comb begin
        count_d          = tail_d - head_d;
        full_d           = (count_d == PW'(N));
        new_spec_valid_d = do_alloc;
        new_spec_id_d    = do_alloc ? tail_idx : new_spec_id_q;
        invalid_d        = do_miss;
        miss_id_d        = do_miss ? miss_pos : miss_id_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            valid_q          <= '0;
            resolved_q       <= '0;
            new_spec_valid_q <= 1'b0;
            new_spec_id_q    <= '0;
            invalid_q        <= 1'b0;
            miss_id_q        <= '0;
            full_q           <= 1'b0;
            count_q          <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            new_spec_valid_q <= new_spec_valid_d;
            new_spec_id_q    <= new_spec_id_d;
            invalid_q        <= invalid_d;
            miss_id_q        <= miss_id_d;
            full_q           <= full_d;
            count_q          <= count_d;
        end
    end

    // Every public output comes straight from a flop.
    assign bus.newSpecValid = new_spec_valid_q;
    assign bus.newSpecId    = new_spec_id_q;
    assign bus.invalid      = invalid_q;
    assign bus.missId       = miss_id_q;
    assign bus.full         = full_q;
    assign bus.count        = count_q;
endmodule
